// File: rtl/reg_file_pkg.sv
// Shared constants and FSM state type for the register file.
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: index-0 mask, range check and optional write bypass.
// Optional feature macro: RF_WB_BYPASS_EN (same-cycle writeback-to-read forwarding).
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic [XLEN-1:0]      regs_i [NREGS],
    input  logic                 ready_i,
    input  logic [REG_IDX_W-1:0] addr_i,
    input  logic                 wr_en_i,
    input  logic [REG_IDX_W-1:0] wr_idx_i,
    input  logic [XLEN-1:0]      wr_data_i,
    output logic [XLEN-1:0]      data_o
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic in_range;
    logic bypass_hit;

    assign in_range = (int'(addr_i) < NREGS);

`ifdef RF_WB_BYPASS_EN
    // wr_en_i already excludes index 0 and the INIT state.
    assign bypass_hit = wr_en_i && (wr_idx_i == addr_i);
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_en_i, wr_idx_i};
    assign bypass_hit    = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        data_o = '0;
        if (ready_i && in_range && (addr_i != '0)) begin
            data_o = regs_i[addr_i[IDX_W-1:0]];
            if (bypass_hit) begin
                data_o = wr_data_i;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file cleared by a post-reset sweep (INIT) before use (RUN).
// Optional feature macro: RF_WB_BYPASS_EN (same-cycle writeback-to-read forwarding).
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 regwrite_in,
    input  logic [REG_IDX_W-1:0] rd_in,
    input  logic [XLEN-1:0]      wdata_in,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 rf_ready
);

    localparam int                   IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NREGS - 1);

    rf_state_t            state_q, state_d;
    logic [REG_IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic                 rf_ready_q, rf_ready_d;
    logic [XLEN-1:0]      regs_q [NREGS];
    logic                 wr_valid;

    assign wr_valid = regwrite_in && (state_q == RF_RUN) && (rd_in != '0)
                      && (int'(rd_in) < NREGS);
    assign rf_ready = rf_ready_q;

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        rf_ready_d = rf_ready_q;
        case (state_q)
            RF_INIT: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d    = RF_RUN;
                    rf_ready_d = 1'b1;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_INIT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RF_INIT;
            clr_idx_q  <= REG_IDX_W'(1);
            rf_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rf_ready_q <= rf_ready_d;
        end
    end

    // NOTE: the array has no reset net; the INIT sweep clears it, letting it map to plain storage.
    always_ff @(posedge clk) begin
        if (state_q == RF_INIT) begin
            regs_q[clr_idx_q[IDX_W-1:0]] <= '0;
        end else if (wr_valid) begin
            regs_q[rd_in[IDX_W-1:0]] <= wdata_in;
        end
    end

    rf_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_rd1 (
        .regs_i    (regs_q),
        .ready_i   (rf_ready_q),
        .addr_i    (rs1_addr),
        .wr_en_i   (wr_valid),
        .wr_idx_i  (rd_in),
        .wr_data_i (wdata_in),
        .data_o    (rs1_data)
    );

    rf_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_rd2 (
        .regs_i    (regs_q),
        .ready_i   (rf_ready_q),
        .addr_i    (rs2_addr),
        .wr_en_i   (wr_valid),
        .wr_idx_i  (rd_in),
        .wr_data_i (wdata_in),
        .data_o    (rs2_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: init sweep, writes, x0, same-cycle bypass, reset mid-RUN.
module tb_reg_file;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regwrite_in;
    logic [4:0]  rd_in;
    logic [31:0] wdata_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rf_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file #(.XLEN(32), .NREGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .regwrite_in (regwrite_in),
        .rd_in       (rd_in),
        .wdata_in    (wdata_in),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rf_ready    (rf_ready)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sel(input logic [31:0] forwarded, input logic [31:0] old);
        return BYP ? forwarded : old;
    endfunction

    // Counts rising edges until rf_ready rises; optionally injects a write during INIT.
    task automatic wait_ready(input bit inject, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 5) begin
                check("init_rs1_zero", rs1_data, 32'h0);
                check("init_rs2_zero", rs2_data, 32'h0);
            end
            if (inject && cycles == 9) begin
                regwrite_in = 1'b1;
                rd_in       = 5'd3;
                wdata_in    = 32'h11;
            end
            if (inject && cycles == 10) begin
                regwrite_in = 1'b0;
            end
        end while (!rf_ready && cycles < 100);
        regwrite_in = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic apply_vec(input vec_t v);
        exp_t e;
        regwrite_in = v.we;
        rd_in       = v.rd;
        wdata_in    = v.wd;
        rs1_addr    = v.a1;
        rs2_addr    = v.a2;
        sb.push_back('{v.name, v.e1, v.e2});
        @(negedge clk);
        e = sb.pop_front();
        check({e.name, "_rs1"}, rs1_data, e.e1);
        check({e.name, "_rs2"}, rs2_data, e.e2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cycles;

        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  sel(32'hDEADBEEF, 32'h0), 32'h0, "wr_x5"};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, "rd_x5"};
        vecs[2]  = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0, 32'hDEADBEEF, "wr_x0"};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0, "rd_x0"};
        vecs[4]  = '{1'b1, 5'd7,  32'h11110000, 5'd7,  5'd0,  sel(32'h11110000, 32'h0), 32'h0, "wr_x7_old"};
        vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd5,  5'd7,  32'hDEADBEEF, sel(32'hA5A5A5A5, 32'h11110000), "byp_x7"};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, "rd_x7"};
        vecs[7]  = '{1'b1, 5'd12, 32'hCAFE0001, 5'd12, 5'd12, sel(32'hCAFE0001, 32'h0), sel(32'hCAFE0001, 32'h0), "wr_x12"};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd12, 5'd12, 32'hCAFE0001, 32'hCAFE0001, "rd_x12"};
        vecs[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, sel(32'hFFFFFFFF, 32'h0), 32'h0, "wr_x31"};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd3,  32'hFFFFFFFF, 32'h0, "rd_x31"};
        vecs[11] = '{1'b1, 5'd9,  32'h55,       5'd9,  5'd0,  sel(32'h55, 32'h0), 32'h0, "wr_x9"};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd5,  32'h55, 32'hDEADBEEF, "rd_x9"};

        rst_n       = 1'b0;
        regwrite_in = 1'b0;
        rd_in       = 5'd0;
        wdata_in    = 32'h0;
        rs1_addr    = 5'd20;
        rs2_addr    = 5'd31;
        #12;
        check("reset_ready", {31'b0, rf_ready}, 32'h0);
        check("reset_rs1", rs1_data, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(1'b1, cycles);
        check("sweep_latency", cycles, 32'd31);

        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(32 - i);
            @(negedge clk);
            check($sformatf("sweep_x%0d", i), rs1_data, 32'h0);
            check($sformatf("sweep_x%0d_p2", 32 - i), rs2_data, 32'h0);
            @(posedge clk);
            #1;
        end

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
        end
        regwrite_in = 1'b0;
        check("sb_drained", sb.size(), 32'd0);

        rs1_addr = 5'd9;
        rs2_addr = 5'd5;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_ready", {31'b0, rf_ready}, 32'h0);
        check("async_reset_rs1", rs1_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(1'b0, cycles);
        check("resweep_latency", cycles, 32'd31);
        @(negedge clk);
        check("resweep_x9", rs1_data, 32'h0);
        check("resweep_x5", rs2_data, 32'h0);
        check("resweep_ready", {31'b0, rf_ready}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
